// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy, almost-full/empty flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         r_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr, r_ptr;
    logic                  wr_ok, rd_ok;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    assign wr_ok        = w_en & ~full;
    assign rd_ok        = r_en & ~empty;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= w_en & full;
            underflow <= r_en & empty;
            if (wr_ok) w_ptr <= (w_ptr == PW'(DEPTH - 1)) ? '0 : w_ptr + 1'b1;
            if (rd_ok) r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
            if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_ptr] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[r_ptr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out <= '0;
        else if (rd_ok) data_out <= mem[r_ptr];
    end
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scoreboard bench for sync_fifo_flags at DEPTH=8 and DEPTH=5.
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w8, r8, w5, r5;
    logic [7:0] d8, d5, q8, q5;
    logic       f8, e8, af8, ae8, ov8, un8;
    logic       f5, e5, af5, ae5, ov5, un5;
    logic [3:0] c8;
    logic [2:0] c5;

    always #5 clk = ~clk;

    sync_fifo_flags u8 (
        .clk(clk), .rst_n(rst_n), .w_en(w8), .data_in(d8), .r_en(r8), .data_out(q8),
        .full(f8), .empty(e8), .almost_full(af8), .almost_empty(ae8), .count(c8),
        .overflow(ov8), .underflow(un8)
    );

    sync_fifo_flags #(.DEPTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .w_en(w5), .data_in(d5), .r_en(r5), .data_out(q5),
        .full(f5), .empty(e5), .almost_full(af5), .almost_empty(ae5), .count(c5),
        .overflow(ov5), .underflow(un5)
    );

    typedef struct {
        int         inst;
        logic [3:0] c;
        logic       ov;
        logic       un;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected flags are decoded from the hand-given count and each instance's thresholds.
    initial begin : monitor
        exp_t       e;
        int         dep, aft;
        string      p;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e   = q.pop_front();
                dep = e.inst != 0 ? 5 : 8;
                aft = e.inst != 0 ? 4 : 7;
                p   = $sformatf("d%0d_", dep);
                if (e.inst != 0) begin
                    chk({p, "count"}, {5'b0, c5}, {4'b0, e.c});
                    chk({p, "full"}, f5, e.c == 4'(dep));
                    chk({p, "empty"}, e5, e.c == 4'd0);
                    chk({p, "almost_full"}, af5, e.c >= 4'(aft));
                    chk({p, "almost_empty"}, ae5, e.c <= 4'd1);
                    chk({p, "overflow"}, ov5, e.ov);
                    chk({p, "underflow"}, un5, e.un);
                    chk({p, "data_out"}, q5, e.d);
                end else begin
                    chk({p, "count"}, {4'b0, c8}, {4'b0, e.c});
                    chk({p, "full"}, f8, e.c == 4'(dep));
                    chk({p, "empty"}, e8, e.c == 4'd0);
                    chk({p, "almost_full"}, af8, e.c >= 4'(aft));
                    chk({p, "almost_empty"}, ae8, e.c <= 4'd1);
                    chk({p, "overflow"}, ov8, e.ov);
                    chk({p, "underflow"}, un8, e.un);
                    chk({p, "data_out"}, q8, e.d);
                end
            end
        end
    end

    task automatic step(input int inst, input logic w, input logic [7:0] d, input logic r,
                        input logic [3:0] c, input logic ov, input logic un, input logic [7:0] dv);
        exp_t e;
        @(negedge clk);
        if (inst != 0) begin
            w5 = w; d5 = d; r5 = r;
        end else begin
            w8 = w; d8 = d; r8 = r;
        end
        e.inst = inst; e.c = c; e.ov = ov; e.un = un; e.d = dv;
        q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        w8 = 1'b0; r8 = 1'b0; w5 = 1'b0; r5 = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        w8 = 1'b0; r8 = 1'b0; d8 = '0;
        w5 = 1'b0; r5 = 1'b0; d5 = '0;
        #12;
        chk("rst_count", {4'b0, c8}, 8'd0);
        chk("rst_empty", e8, 1'b1);
        chk("rst_full", f8, 1'b0);
        chk("rst_almost_empty", ae8, 1'b1);
        chk("rst_almost_full", af8, 1'b0);
        chk("rst_data_out", q8, 8'h00);
        chk("rst_overflow", ov8, 1'b0);
        chk("rst_underflow", un8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
`ifdef FIFO_FWFT_EN
        step(0, 1'b1, 8'h3C, 1'b0, 4'd1, 1'b0, 1'b0, 8'h3C);
        step(0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 8'h3C);
        step(0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00);
        drain();
`else
        for (int i = 1; i <= 8; i++) step(0, 1'b1, 8'(i), 1'b0, 4'(i), 1'b0, 1'b0, 8'h00);
        step(0, 1'b1, 8'hFF, 1'b0, 4'd8, 1'b1, 1'b0, 8'h00);
        step(0, 1'b0, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) step(0, 1'b0, 8'h00, 1'b1, 4'(8 - i), 1'b0, 1'b0, 8'(i));
        step(0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 8'h08);
        for (int i = 1; i <= 8; i++) step(0, 1'b1, 8'(8'h10 + i), 1'b0, 4'(i), 1'b0, 1'b0, 8'h08);
        step(0, 1'b1, 8'h99, 1'b1, 4'd7, 1'b1, 1'b0, 8'h11);
        for (int i = 2; i <= 8; i++) step(0, 1'b0, 8'h00, 1'b1, 4'(8 - i), 1'b0, 1'b0, 8'(8'h10 + i));
        step(0, 1'b1, 8'h77, 1'b1, 4'd1, 1'b0, 1'b1, 8'h18);
        step(0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h77);
        step(0, 1'b1, 8'h21, 1'b0, 4'd1, 1'b0, 1'b0, 8'h77);
        step(0, 1'b1, 8'h22, 1'b1, 4'd1, 1'b0, 1'b0, 8'h21);
        step(0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h22);
        drain();
        // Non-power-of-two depth: three rounds force both pointers through the 4->0 wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= 4; k++)
                step(1, 1'b1, 8'(8'h40 + r * 8 + k), 1'b0, 4'(k), 1'b0, 1'b0,
                     r == 0 ? 8'h00 : 8'(8'h40 + (r - 1) * 8 + 4));
            for (int k = 1; k <= 4; k++)
                step(1, 1'b0, 8'h00, 1'b1, 4'(4 - k), 1'b0, 1'b0, 8'(8'h40 + r * 8 + k));
        end
        for (int k = 1; k <= 5; k++) step(1, 1'b1, 8'(8'h50 + k), 1'b0, 4'(k), 1'b0, 1'b0, 8'h54);
        step(1, 1'b1, 8'hEE, 1'b0, 4'd5, 1'b1, 1'b0, 8'h54);
        drain();
        for (int i = 1; i <= 5; i++) step(0, 1'b1, 8'(8'h30 + i), 1'b0, 4'(i), 1'b0, 1'b0, 8'h22);
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", {4'b0, c8}, 8'd0);
        chk("async_rst_empty", e8, 1'b1);
        chk("async_rst_data_out", q8, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, 8'hA5, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00);
        step(0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'hA5);
        drain();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
